// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_DATA_WIDTH = 32;
    localparam int unsigned MDU_ITERATIONS = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // Quotient reported for a zero divisor
    localparam logic [MDU_DATA_WIDTH-1:0] MDU_DIV_ZERO_LO = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] din,
    input  logic         negate,
    output logic [W-1:0] dout_c
);

    assign dout_c = negate ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider with Start/Busy/Done handshake.
// Signed MULT/DIV support is compiled in with `define MDU_SIGNED_OPS_EN.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [DATA_WIDTH-1:0] Operand_A,
    input  logic [DATA_WIDTH-1:0] Operand_B,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo,
    output logic                  Div_By_Zero
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(MDU_ITERATIONS);

    mdu_state_e      state;
    logic [1:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    m_q;
    logic [2*W-1:0]  acc_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_xor_q;
    logic            neg_a_q;

    logic            is_div;
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W+1:0]    div_diff;
    logic [2*W-1:0]  div_next;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;
    logic            unused_div_bit;

    assign is_div = (op_q == OP_DIVU) || (op_q == OP_DIV);

`ifdef MDU_SIGNED_OPS_EN
    assign signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
`else
    assign signed_op = 1'b0;
`endif

    assign a_neg = signed_op & a_q[W-1];
    assign b_neg = signed_op & b_q[W-1];

    mdu_sign_fix #(.W(W)) u_mag_a (.din(a_q), .negate(a_neg), .dout_c(a_mag));
    mdu_sign_fix #(.W(W)) u_mag_b (.din(b_q), .negate(b_neg), .dout_c(b_mag));

    // Multiply step: conditionally add multiplicand to the upper half, then shift right
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide step: trial-subtract divisor from the shifted remainder, keep result if non-negative
    assign div_diff = {1'b0, acc_q[2*W-1:W-1]} - {2'b00, m_q};
    assign div_next = div_diff[W+1] ? {acc_q[2*W-2:0], 1'b0}
                                    : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    assign unused_div_bit = div_diff[W];

    mdu_sign_fix #(.W(2*W)) u_fix_prod (.din(acc_q),            .negate(neg_xor_q), .dout_c(prod_fix));
    mdu_sign_fix #(.W(W))   u_fix_quo  (.din(acc_q[W-1:0]),     .negate(neg_xor_q), .dout_c(quo_fix));
    mdu_sign_fix #(.W(W))   u_fix_rem  (.din(acc_q[2*W-1:W]),   .negate(neg_a_q),   .dout_c(rem_fix));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= OP_MULTU;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_xor_q   <= 1'b0;
            neg_a_q     <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Hi          <= '0;
            Lo          <= '0;
            Div_By_Zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op_q        <= Op;
                        a_q         <= Operand_A;
                        b_q         <= Operand_B;
                        Div_By_Zero <= 1'b0;
                        Busy        <= 1'b1;
                        state       <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (is_div && (b_q == '0)) begin
                        Hi          <= a_q;
                        Lo          <= W'(MDU_DIV_ZERO_LO);
                        Div_By_Zero <= 1'b1;
                        Busy        <= 1'b0;
                        Done        <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        acc_q     <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
                        m_q       <= is_div ? b_mag : a_mag;
                        neg_xor_q <= a_neg ^ b_neg;
                        neg_a_q   <= a_neg;
                        cnt_q     <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= is_div ? div_next : mul_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(MDU_ITERATIONS - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (is_div) begin
                        Hi <= rem_fix;
                        Lo <= quo_fix;
                    end else begin
                        Hi <= prod_fix[2*W-1:W];
                        Lo <= prod_fix[W-1:0];
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    Done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit; signed cases follow MDU_SIGNED_OPS_EN.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Div_By_Zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .Op         (Op),
        .Operand_A  (Operand_A),
        .Operand_B  (Operand_B),
        .Busy       (Busy),
        .Done       (Done),
        .Hi         (Hi),
        .Lo         (Lo),
        .Div_By_Zero(Div_By_Zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference result {Hi, Lo} using native 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit             sgn;
        longint         sa, sb2, sq, sr;
        longint unsigned ua, ub;
`ifdef MDU_SIGNED_OPS_EN
        sgn = op[1];
`else
        sgn = 1'b0;
`endif
        sa  = $signed(a);
        sb2 = $signed(b);
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        if (!op[0]) begin
            if (sgn) return 64'(sa * sb2);
            return ua * ub;
        end
        if (b == 32'b0) return {a, 32'hFFFFFFFF};
        if (sgn) begin
            sq = sa / sb2;
            sr = sa % sb2;
            return {sr[31:0], sq[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Caller must be at a negedge with the DUT idle; Start is driven immediately
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit perturb);
        exp_t        e;
        exp_t        got;
        logic [63:0] m;
        logic [31:0] prev_hi, prev_lo;
        int          k;
        bit          busy_ok;
        m     = model(op, a, b);
        e.hi  = m[63:32];
        e.lo  = m[31:0];
        e.dbz = op[0] && (b == 32'b0);
        e.lat = e.dbz ? 1 : 34;
        sb.push_back(e);
        prev_hi   = Hi;
        prev_lo   = Lo;
        Start     = 1'b1;
        Op        = op;
        Operand_A = a;
        Operand_B = b;
        @(negedge clk);
        Start     = 1'b0;
        Operand_A = $urandom;
        Operand_B = $urandom;
        check({tag, " busy_after_start"}, 64'(Busy), 64'd1);
        k       = 0;
        busy_ok = 1'b1;
        while (!Done && k < 100) begin
            if (k == 3) check({tag, " hilo_hold"}, {Hi, Lo}, {prev_hi, prev_lo});
            if (perturb && k == 5) begin
                Start     = 1'b1;
                Op        = ~op;
                Operand_A = $urandom;
                Operand_B = $urandom;
            end
            if (perturb && k == 6) Start = 1'b0;
            @(negedge clk);
            k++;
            if (!Done && !Busy) busy_ok = 1'b0;
        end
        got = sb.pop_front();
        check({tag, " latency"}, 64'(k), 64'(got.lat));
        check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_at_done"}, 64'(Busy), 64'd0);
        check({tag, " hi"}, 64'(Hi), 64'(got.hi));
        check({tag, " lo"}, 64'(Lo), 64'(got.lo));
        check({tag, " dbz"}, 64'(Div_By_Zero), 64'(got.dbz));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(Done), 64'd0);
        if (perturb) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check({tag, " no_extra_done"}, {62'b0, Done, Busy}, 64'd0);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        Start     = 1'b0;
        Op        = 2'b00;
        Operand_A = '0;
        Operand_B = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        check("reset hi", 64'(Hi), 64'd0);
        check("reset lo", 64'(Lo), 64'd0);
        check("reset dbz", 64'(Div_By_Zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 1'b0);
        run_op(2'b01, 32'd100, 32'd7, "divu_100_7", 1'b0);
        run_op(2'b01, 32'd5, 32'd0, "divu_by_zero", 1'b0);
        run_op(2'b01, 32'd0, 32'd9, "divu_zero_dividend", 1'b0);
        run_op(2'b00, 32'd0, 32'd1234, "multu_zero", 1'b0);
        run_op(2'b01, 32'h12345678, 32'hFFFFFFFF, "divu_big_divisor", 1'b0);
`ifdef MDU_SIGNED_OPS_EN
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, "div_neg7_2", 1'b0);
        run_op(2'b10, 32'hFFFFFFFD, 32'd5, "mult_neg3_5", 1'b0);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, "div_min_neg1", 1'b0);
        run_op(2'b11, 32'd7, 32'hFFFFFFFE, "div_7_neg2", 1'b0);
        run_op(2'b10, 32'h80000000, 32'h80000000, "mult_min_min", 1'b0);
        run_op(2'b11, 32'hFFFFFFFB, 32'd0, "div_neg5_zero", 1'b0);
`else
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, "op11_unsigned", 1'b0);
        run_op(2'b10, 32'hFFFFFFFD, 32'd5, "op10_unsigned", 1'b0);
`endif
        for (int i = 0; i < 4; i++) begin
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 32'hFFFF), "random", 1'b0);
        end
        run_op(2'b00, 32'd12345, 32'd6789, "start_during_run", 1'b1);

        // Abort a multiply at RUN iteration 10 with an asynchronous reset
        Start     = 1'b1;
        Op        = 2'b00;
        Operand_A = 32'hDEADBEEF;
        Operand_B = 32'h0BADF00D;
        @(negedge clk);
        Start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", 64'(Busy), 64'd0);
        check("abort done", 64'(Done), 64'd0);
        check("abort hi", 64'(Hi), 64'd0);
        check("abort lo", 64'(Lo), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b00, 32'd6, 32'd7, "multu_after_reset", 1'b0);

        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
